// File: rtl/analog_stim_player_if.sv
// Handshake and playback bus between a stimulus source and analog_stim_player.
// The master drives the samples and controls; the slave returns the stimulus outputs.
interface analog_stim_player_if #(
  parameter int WIDTH = 25,
  parameter int PER_W = 16
);
  logic [WIDTH-1:0] wr_data;
  logic             wr_valid;
  logic             wr_ready;
  logic             start;
  logic             stop;
  logic             loop;
  logic [PER_W-1:0] period;
  logic [WIDTH-1:0] v_out;
  logic             v_out_stb;
  logic             busy;
  logic             done;

  modport master (
    output wr_data, wr_valid, start, stop, loop, period,
    input  wr_ready, v_out, v_out_stb, busy, done
  );

  modport slave (
    input  wr_data, wr_valid, start, stop, loop, period,
    output wr_ready, v_out, v_out_stb, busy, done
  );
endinterface

// File: rtl/analog_stim_player.sv
// Buffered sample player: plays loaded samples into an analog model at a programmable rate.
// Define STIM_LOOP_EN to compile in looped (indefinite replay) playback.
module analog_stim_player #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 16,
  parameter int PER_W = 16
) (
  input  logic                 emu_clk,
  input  logic                 emu_rst_n,
  analog_stim_player_if.slave  bus
);
  localparam int          AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

  typedef enum logic {IDLE, RUN} state_t;
  state_t r_state, w_next;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr, r_first_ptr;
  logic [AW:0]      r_count, r_len_q, r_pop_cnt;
  logic [PER_W-1:0] r_tick, r_per_q;
  logic [WIDTH-1:0] r_v_out;
  logic             r_stb, r_done, r_loop_q;
  logic             w_start, w_pop, w_wr, w_loop_start, w_wrap, w_drain;

`ifdef STIM_LOOP_EN
  assign w_loop_start = bus.loop;
`else
  assign w_loop_start = 1'b0;
`endif

  assign bus.wr_ready  = (r_count < FULL) && !((r_state == RUN) && r_loop_q);
  assign bus.v_out     = r_v_out;
  assign bus.v_out_stb = r_stb;
  assign bus.busy      = (r_state == RUN);
  assign bus.done      = r_done;

  assign w_wr    = bus.wr_valid && bus.wr_ready;
  assign w_start = (r_state == IDLE) && bus.start && (r_count != '0);
  assign w_pop   = (r_state == RUN) && (r_tick == '0) && !bus.stop;
  assign w_drain = w_pop && !r_loop_q;
  assign w_wrap  = r_loop_q && (r_pop_cnt == (r_len_q - ONE));

  always_ff @(posedge emu_clk or negedge emu_rst_n) begin
    if (!emu_rst_n) r_state <= IDLE;
    else            r_state <= w_next;
  end

  // A draining pop only ends playback when no write refills the last slot on the same edge.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_start) w_next = RUN;
      RUN: begin
        if (bus.stop)                                   w_next = IDLE;
        else if (w_drain && (r_count == ONE) && !w_wr)  w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge emu_clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= bus.wr_data;
  end

  always_ff @(posedge emu_clk or negedge emu_rst_n) begin
    if (!emu_rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_first_ptr <= '0;
      r_count     <= '0;
      r_len_q     <= '0;
      r_pop_cnt   <= '0;
      r_tick      <= '0;
      r_per_q     <= '0;
      r_v_out     <= '0;
      r_stb       <= 1'b0;
      r_done      <= 1'b0;
      r_loop_q    <= 1'b0;
    end else begin
      r_stb  <= w_pop;
      r_done <= (r_state == RUN) && (w_next == IDLE);
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_start) begin
        r_tick      <= '0;
        r_per_q     <= bus.period;
        r_len_q     <= r_count;
        r_first_ptr <= r_rd_ptr;
        r_pop_cnt   <= '0;
        r_loop_q    <= w_loop_start;
      end else if (w_pop) begin
        r_v_out <= r_mem[r_rd_ptr];
        r_tick  <= r_per_q;
        if (w_wrap) begin
          r_rd_ptr  <= r_first_ptr;
          r_pop_cnt <= '0;
        end else begin
          r_rd_ptr  <= r_rd_ptr + 1'b1;
          r_pop_cnt <= r_pop_cnt + ONE;
        end
      end else if ((r_state == RUN) && !bus.stop) begin
        r_tick <= r_tick - 1'b1;
      end
      if (w_wr && !w_drain)      r_count <= r_count + ONE;
      else if (!w_wr && w_drain) r_count <= r_count - ONE;
    end
  end
endmodule

// File: tb/tb_analog_stim_player.sv
// Directed self-checking bench for analog_stim_player (samples in Q3.22 fixed point).
// Runs the looped-playback scenario when built with STIM_LOOP_EN, else checks loop is ignored.
module tb_analog_stim_player;
  localparam int WIDTH = 25;
  localparam int DEPTH = 16;
  localparam int PER_W = 16;

  localparam logic [WIDTH-1:0] S0 = 25'h0100000;
  localparam logic [WIDTH-1:0] S1 = 25'h1E00000;
  localparam logic [WIDTH-1:0] S2 = 25'h0400000;
  localparam logic [WIDTH-1:0] SA = 25'h0111111;
  localparam logic [WIDTH-1:0] SB = 25'h0222222;
  localparam logic [WIDTH-1:0] SC = 25'h0333333;

  logic emu_clk = 1'b0;
  logic emu_rst_n;
  int   checks = 0;
  int   fails  = 0;

  analog_stim_player_if #(.WIDTH(WIDTH), .PER_W(PER_W)) bus ();

  analog_stim_player #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PER_W(PER_W)) dut (
    .emu_clk   (emu_clk),
    .emu_rst_n (emu_rst_n),
    .bus       (bus)
  );

  always #5 emu_clk = ~emu_clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs from a negedge; pulses drop after the following posedge.
  task automatic applyStimulus(input logic wv, input logic [WIDTH-1:0] wd, input logic st,
                               input logic sp, input logic lp, input logic [PER_W-1:0] per);
    bus.wr_valid = wv;
    bus.wr_data  = wd;
    bus.start    = st;
    bus.stop     = sp;
    bus.loop     = lp;
    bus.period   = per;
    @(negedge emu_clk);
    bus.wr_valid = 1'b0;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
  endtask

  task automatic writeSample(input logic [WIDTH-1:0] d);
    applyStimulus(1'b1, d, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  logic             expStb  [8] = '{1, 0, 0, 1, 0, 0, 1, 0};
  logic             expBusy [8] = '{1, 1, 1, 1, 1, 1, 0, 0};
  logic             expDone [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
  logic [WIDTH-1:0] expV    [8] = '{S0, S0, S0, S1, S1, S1, S2, S2};

  initial begin
    int n;
    int doneCnt;
    logic [WIDTH-1:0] fillVal;
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.loop     = 1'b0;
    bus.period   = '0;
    emu_rst_n    = 1'b0;
    #2;
    checkOutput("rst_vout", 32'(bus.v_out), 32'h0);
    checkOutput("rst_busy", 32'(bus.busy), 32'h0);
    checkOutput("rst_ready", 32'(bus.wr_ready), 32'h1);
    checkOutput("rst_done", 32'(bus.done), 32'h0);
    @(negedge emu_clk);
    emu_rst_n = 1'b1;
    idleCycle();

    // Three samples, period 2: updates at k+1, k+4, k+7.
    writeSample(S0);
    writeSample(S1);
    writeSample(S2);
    checkOutput("a_count3", 32'(dut.r_count), 32'd3);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 16'd2);
    checkOutput("a_busy_k", 32'(bus.busy), 32'h1);
    checkOutput("a_vout_k", 32'(bus.v_out), 32'h0);
    for (int c = 0; c < 8; c++) begin
      idleCycle();
      checkOutput($sformatf("a_stb%0d", c + 1), 32'(bus.v_out_stb), 32'(expStb[c]));
      checkOutput($sformatf("a_vout%0d", c + 1), 32'(bus.v_out), 32'(expV[c]));
      checkOutput($sformatf("a_busy%0d", c + 1), 32'(bus.busy), 32'(expBusy[c]));
      checkOutput($sformatf("a_done%0d", c + 1), 32'(bus.done), 32'(expDone[c]));
    end
    checkOutput("a_count0", 32'(dut.r_count), 32'd0);

    // Start on an empty buffer is ignored.
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
    checkOutput("b_busy", 32'(bus.busy), 32'h0);
    checkOutput("b_done", 32'(bus.done), 32'h0);
    checkOutput("b_vout", 32'(bus.v_out), 32'(S2));
    idleCycle();
    checkOutput("b_done2", 32'(bus.done), 32'h0);
    checkOutput("b_stb", 32'(bus.v_out_stb), 32'h0);

    // Fill to capacity, reject a 17th write, then play back at full rate.
    for (int i = 0; i < DEPTH; i++) writeSample(WIDTH'(i + 16));
    checkOutput("c_ready_full", 32'(bus.wr_ready), 32'h0);
    writeSample(25'h1FFFFFF);
    checkOutput("c_count16", 32'(dut.r_count), 32'd16);
    checkOutput("c_ready_full2", 32'(bus.wr_ready), 32'h0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 16'd0);
    n = 0;
    doneCnt = 0;
    for (int c = 0; c < 20; c++) begin
      idleCycle();
      if (bus.done) doneCnt++;
      if (bus.v_out_stb) begin
        fillVal = WIDTH'(n + 16);
        checkOutput($sformatf("c_vout%0d", n), 32'(bus.v_out), 32'(fillVal));
        n++;
      end
    end
    checkOutput("c_strobes", 32'(n), 32'd16);
    checkOutput("c_done_pulses", 32'(doneCnt), 32'd1);
    checkOutput("c_busy_end", 32'(bus.busy), 32'h0);

    // Write coinciding with a pop keeps count and extends playback by one sample.
    writeSample(25'h0000AAA);
    writeSample(25'h1555555);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 16'd0);
    idleCycle();
    checkOutput("d_vout_x", 32'(bus.v_out), 32'h0000AAA);
    writeSample(25'h0123456);
    checkOutput("d_vout_y", 32'(bus.v_out), 32'h1555555);
    checkOutput("d_busy", 32'(bus.busy), 32'h1);
    checkOutput("d_no_done", 32'(bus.done), 32'h0);
    checkOutput("d_count1", 32'(dut.r_count), 32'd1);
    idleCycle();
    checkOutput("d_vout_z", 32'(bus.v_out), 32'h0123456);
    checkOutput("d_busy_end", 32'(bus.busy), 32'h0);
    checkOutput("d_done", 32'(bus.done), 32'h1);

    // Stop on the edge a pop is due: no update, buffer keeps the unplayed sample.
    writeSample(SA);
    writeSample(SB);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 16'd3);
    idleCycle();
    checkOutput("e_vout_a", 32'(bus.v_out), 32'(SA));
    idleCycle();
    idleCycle();
    idleCycle();
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
    checkOutput("e_busy", 32'(bus.busy), 32'h0);
    checkOutput("e_done", 32'(bus.done), 32'h1);
    checkOutput("e_stb", 32'(bus.v_out_stb), 32'h0);
    checkOutput("e_vout_hold", 32'(bus.v_out), 32'(SA));
    checkOutput("e_count1", 32'(dut.r_count), 32'd1);
    idleCycle();
    checkOutput("e_done_clr", 32'(bus.done), 32'h0);

    // Asynchronous reset in the middle of playback.
    writeSample(SC);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 16'd5);
    idleCycle();
    checkOutput("f_vout_b", 32'(bus.v_out), 32'(SB));
    checkOutput("f_busy", 32'(bus.busy), 32'h1);
    #2 emu_rst_n = 1'b0;
    #1;
    checkOutput("f_rst_vout", 32'(bus.v_out), 32'h0);
    checkOutput("f_rst_busy", 32'(bus.busy), 32'h0);
    checkOutput("f_rst_ready", 32'(bus.wr_ready), 32'h1);
    checkOutput("f_rst_count", 32'(dut.r_count), 32'd0);
    @(negedge emu_clk);
    emu_rst_n = 1'b1;
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
    checkOutput("f_post_busy", 32'(bus.busy), 32'h0);

    writeSample(SA);
    writeSample(SB);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1, 16'd0);
`ifdef STIM_LOOP_EN
    checkOutput("g_ready_loop", 32'(bus.wr_ready), 32'h0);
    for (int c = 0; c < 5; c++) begin
      idleCycle();
      checkOutput($sformatf("g_loop_stb%0d", c), 32'(bus.v_out_stb), 32'h1);
      checkOutput($sformatf("g_loop_vout%0d", c), 32'(bus.v_out), (c % 2 == 0) ? 32'(SA) : 32'(SB));
    end
    checkOutput("g_busy_loop", 32'(bus.busy), 32'h1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
    checkOutput("g_busy_stop", 32'(bus.busy), 32'h0);
    checkOutput("g_done", 32'(bus.done), 32'h1);
    checkOutput("g_stb_stop", 32'(bus.v_out_stb), 32'h0);
    checkOutput("g_vout_hold", 32'(bus.v_out), 32'(SA));
    checkOutput("g_count2", 32'(dut.r_count), 32'd2);
`else
    idleCycle();
    checkOutput("g_vout_a", 32'(bus.v_out), 32'(SA));
    checkOutput("g_busy_a", 32'(bus.busy), 32'h1);
    idleCycle();
    checkOutput("g_vout_b", 32'(bus.v_out), 32'(SB));
    checkOutput("g_busy_end", 32'(bus.busy), 32'h0);
    checkOutput("g_done", 32'(bus.done), 32'h1);
    checkOutput("g_count0", 32'(dut.r_count), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
